// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and read-mode constants for the FIFO slice.
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction
  function automatic bit is_pow2(input int v);
    return v >= 1 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_W storage, synchronous write, asynchronous read.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, status flags, error pulses
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_TH = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int ADDR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  if (DATA_W < 1 || DEPTH < 2 || !is_pow2(DEPTH) || AFULL_TH < 1 || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1 ||
      (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_params
    $error("sync_fifo_param: illegal parameter combination");
  end
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q;
  logic wr_acc, rd_acc;
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CNT_W'(AFULL_TH);
  assign almost_empty = count <= CNT_W'(AEMPTY_TH);
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_acc);
      rd_ptr <= rd_ptr + ADDR_W'(rd_acc);
      count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      overflow <= wr_en & full;
      underflow <= rd_en & empty;
    end
  fifo_mem_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(wr_acc & ~rst),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_q)
  );
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // empty masks the unwritten/stale head entry
    assign rd_data = empty ? '0 : mem_q;
  end else begin : g_std
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk)
      if (rst) rd_q <= '0;
      else if (rd_acc) rd_q <= mem_q;
    assign rd_data = rd_q;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO with internal read/write pointers, occupancy count, status flags and error pulses. It replaces explicitly addressed 16x8 register-file buffers wherever true first-in-first-out ordering is required. It sits between a producer and consumer in the same clock domain. It supports a registered-read mode and a first-word-fall-through (FWFT) mode.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_TH, 12, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word visible without a read

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  1-cycle pulse: write rejected because FIFO was full
underflow  out  1  1-cycle pulse: read rejected because FIFO was empty

Behaviour:
- ADDR_W = $clog2(DEPTH). wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0. count is a separate register.
- Write accepted (wr_acc) = wr_en & ~full. On accept, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read accepted (rd_acc) = rd_en & ~empty. On accept, rd_ptr increments.
- Acceptance is evaluated on the registered flags at the start of the cycle.
- Simultaneous events:
  - Both accepted: count unchanged and both pointers advance.
  - Full with wr_en & rd_en: the read is accepted, the write is rejected, overflow pulses and count becomes DEPTH-1.
  - Empty with wr_en & rd_en: the write is accepted, the read is rejected, underflow pulses and count becomes 1.
- count update: count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Flags are decoded combinationally from the count register, so they reflect an accept on the cycle after it.
- overflow and underflow are registered. Each is high for exactly one cycle following the rejected request.
- FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and is valid the next cycle. rd_data holds its value on all other cycles, including rejected reads.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally while ~empty, and 0 while empty.
  - rd_en consumes the word currently shown.
  - A word written into an empty FIFO appears on rd_data the cycle after the write.
- Reset (at any time, including mid-burst):
  - wr_ptr = rd_ptr = 0 and count = 0.
  - rd_data = 0, empty = 1, almost_empty = 1.
  - full = 0, almost_full = 0 (AFULL_TH >= 1), overflow = 0, underflow = 0.
  - wr_en and rd_en are ignored during the reset cycle. Stored words are discarded logically.
- Memory array is not reset. Outputs never expose unwritten entries.
- Illegal parameter values (DEPTH not a power of two, thresholds out of range) are flagged by an elaboration-time check.

Decomposition:
- Shared package fifo_pkg:
  - function clog2 helper.
  - Localparam conventions for pointer/count widths.
  - Enum-style constants FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
- One sub-module: fifo_mem_dp, a DEPTH x DATA_W storage array with a synchronous write port and an asynchronous read port. The FIFO wrapper adds the output register for FWFT=0.
- Pointer, count and flag logic stay in sync_fifo_param.

Test Plan:
1. Reset, then write 0x01..0x10 on 16 consecutive cycles (DEPTH=16) -> count steps 1..16; almost_full rises when count reaches 12; full = 1 after the 16th write; a 17th write pulses overflow and count stays 16.
2. Read 16 words with FWFT=0 -> rd_data equals 0x01..0x10 in order, each one cycle after its rd_en; empty = 1 at the end; one further rd_en pulses underflow and rd_data holds 0x10.
3. Wrap-around: write 10 words, read 10 words, then write 10 words 0xA0..0xA9 and read them back -> data is in order across pointer wrap (wr_ptr passes 15 -> 0) and count returns to 0.
4. Simultaneous wr_en & rd_en at count = 5 for 8 cycles -> count stays 5 and output order is preserved. At full with both asserted -> count = 15 and overflow pulses. At empty with both asserted -> count = 1 and underflow pulses.
5. FWFT=1: write 0x5A into an empty FIFO -> rd_data = 0x5A the next cycle with no rd_en; rd_en for one cycle -> empty = 1 and rd_data = 0.
6. Assert rst with count = 9 while wr_en & rd_en are high -> next cycle count = 0, empty = 1, almost_empty = 1, rd_data = 0, no overflow or underflow pulse; a subsequent write/read returns the new data, not stale contents.
